// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the iteration-counter sizing helper.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter must hold 0..WIDTH inclusive.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_w(DIV_WIDTH);

endpackage

// File: rtl/div_cla_sub.sv
// N-bit subtractor a - b computed as a + ~b + 1 using 4-bit carry-lookahead
// groups and a group-level carry chain. borrow_n=1 means the result is non-negative.
module div_cla_sub #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow_n
);

    localparam int NG = (N + 3) / 4;
    localparam int W4 = 4 * NG;

    logic [W4-1:0] ap, bp, p, g, c, s;
    logic [NG-1:0] gg, pg;
    logic [NG:0]   cg;
    logic          unused_pad;

    // Pad bits get a=0, ~b=1: they propagate, so the top group carry equals
    // the carry out of bit N-1.
    always_comb begin
        ap = '0;
        bp = '1;
        ap[N-1:0] = a;
        bp[N-1:0] = ~b;
        p  = ap ^ bp;
        g  = ap & bp;
        c  = '0;
        gg = '0;
        pg = '0;
        cg = '0;
        cg[0] = 1'b1;
        for (int k = 0; k < NG; k++) begin
            c[4*k]   = cg[k];
            c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & cg[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pg[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            cg[k+1] = gg[k] | (pg[k] & cg[k]);
        end
        s = p ^ c;
    end

    assign diff       = s[N-1:0];
    assign borrow_n   = cg[NG];
    assign unused_pad = ^s;

endmodule

// File: rtl/seq_divider_16bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock through a
// single WIDTH+1-bit CLA subtractor, with a start/done handshake.
module seq_divider_16bit
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r, t, diff;
    logic [WIDTH-1:0] q, dvsr;
    logic             dbz_pend, borrow_n, last_iter, unused_r;

    assign t         = {r[WIDTH-1:0], q[WIDTH-1]};
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign busy      = (state != S_IDLE);
    // R < divisor after every step, so its MSB is always zero between iterations.
    assign unused_r  = r[WIDTH];

    div_cla_sub #(.N(WIDTH + 1)) u_sub (
        .a        (t),
        .b        ({1'b0, dvsr}),
        .diff     (diff),
        .borrow_n (borrow_n)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (divisor == '0) ? S_DONE : S_RUN;
            S_RUN:   if (last_iter) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            r           <= '0;
            q           <= '0;
            dvsr        <= '0;
            dbz_pend    <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt         <= '0;
                        dvsr        <= divisor;
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        // Divide-by-zero preloads the defined result and skips RUN.
                        if (divisor == '0) begin
                            r        <= {1'b0, dividend};
                            q        <= '1;
                            dbz_pend <= 1'b1;
                        end else begin
                            r        <= '0;
                            q        <= dividend;
                            dbz_pend <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    r   <= borrow_n ? diff : t;
                    q   <= {q[WIDTH-2:0], borrow_n};
                    cnt <= cnt + 1'b1;
                end
                S_DONE: begin
                    quotient    <= q;
                    remainder   <= r[WIDTH-1:0];
                    div_by_zero <= dbz_pend;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
